// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command controller.
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StWr,
      StRdFetch,
      StRdLoad,
      StRdWait
   } state_e;

   localparam int unsigned CMD_WRITE_BIT     = 7;
   localparam logic [3:0]  STATUS_ID_DEFAULT = 4'hA;

endpackage

// File: rtl/cs_sync.sv
// Two-flop synchroniser for the raw chip select with rising/falling edge detect.
module cs_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cs_i,
   output logic fall_o,
   output logic rise_o
);

   logic [1:0] sync_q, sync_d;
   logic       prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[0], cs_i};
      prev_d = sync_q[1];
   end

   // Reset to "deselected" so releasing reset never fakes a cs edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 2'b11;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign fall_o = prev_q & ~sync_q[1];
   assign rise_o = ~prev_q & sync_q[1];

endmodule

// File: rtl/spi_cmd_controller.sv
// Turns the SPI slave word stream into a command/register protocol: a command word
// selects read or write and the start address, following words stream to/from the bus.
module spi_cmd_controller
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned ADDR_W    = 7,
   parameter logic [3:0]  STATUS_ID = STATUS_ID_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              spi_rx_valid,
   input  logic [WORD_W-1:0] spi_rx_data,
   output logic              spi_tx_valid,
   output logic [WORD_W-1:0] spi_tx_data,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [WORD_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [WORD_W-1:0] reg_rdata,
   output logic              intr
);

   logic cs_fall, cs_rise;

   cs_sync u_cs_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .cs_i   (cs),
      .fall_o (cs_fall),
      .rise_o (cs_rise)
   );

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_seen_q, wr_seen_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              tx_valid_q, tx_valid_d;
   logic [WORD_W-1:0] tx_data_q, tx_data_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [WORD_W-1:0] reg_wdata_q, reg_wdata_d;
   logic              reg_we_q, reg_we_d;
   logic              reg_re_q, reg_re_d;
   logic [7:0]        status;

   assign status = {STATUS_ID, 2'b00, overrun_q, pending_q};

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_seen_d   = wr_seen_q;
      pending_d   = pending_q;
      overrun_d   = overrun_q;
      tx_valid_d  = 1'b0;
      tx_data_d   = tx_data_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      reg_re_d    = 1'b0;

      unique case (state_q)
         StCmd: begin
            if (spi_rx_valid) begin
               addr_d = spi_rx_data[ADDR_W-1:0];
               if (spi_rx_data[CMD_WRITE_BIT]) begin
                  state_d = StWr;
               end else begin
                  // Issue the first fetch straight from the command word to save a cycle.
                  state_d    = StRdFetch;
                  pending_d  = 1'b0;
                  overrun_d  = 1'b0;
                  reg_re_d   = 1'b1;
                  reg_addr_d = spi_rx_data[ADDR_W-1:0];
               end
            end
         end
         StWr: begin
            if (spi_rx_valid) begin
               reg_we_d    = 1'b1;
               reg_wdata_d = spi_rx_data;
               reg_addr_d  = addr_q;
               addr_d      = addr_q + 1'b1;
               wr_seen_d   = 1'b1;
            end
         end
         StRdFetch: begin
            state_d = StRdLoad;
            if (spi_rx_valid) overrun_d = 1'b1;
         end
         StRdLoad: begin
            tx_data_d  = reg_rdata;
            tx_valid_d = 1'b1;
            addr_d     = addr_q + 1'b1;
            state_d    = StRdWait;
            if (spi_rx_valid) overrun_d = 1'b1;
         end
         StRdWait: begin
            if (spi_rx_valid) begin
               reg_re_d   = 1'b1;
               reg_addr_d = addr_q;
               state_d    = StRdFetch;
            end
         end
         default: state_d = StIdle;
      endcase

      // Frame boundaries override whatever the word handling above decided.
      if (cs_rise) begin
         state_d    = StIdle;
         tx_valid_d = 1'b0;
         if (wr_seen_d) pending_d = 1'b1;
      end
      if (cs_fall) begin
         state_d    = StCmd;
         tx_valid_d = 1'b1;
         tx_data_d  = WORD_W'(status);
         wr_seen_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wr_seen_q   <= 1'b0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_re_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_seen_q   <= wr_seen_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_re_q    <= reg_re_d;
      end
   end

   assign spi_tx_valid = tx_valid_q;
   assign spi_tx_data  = tx_data_q;
   assign reg_addr     = reg_addr_q;
   assign reg_wdata    = reg_wdata_q;
   assign reg_we       = reg_we_q;
   assign reg_re       = reg_re_q;
   assign intr         = pending_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Randomised frame-level bench for spi_cmd_controller with a register-bank model.
module tb_spi_cmd_controller;

   logic       clk;
   logic       rst;
   logic       cs;
   logic       spi_rx_valid;
   logic [7:0] spi_rx_data;
   logic       spi_tx_valid;
   logic [7:0] spi_tx_data;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       intr;

   spi_cmd_controller dut (
      .clk          (clk),
      .rst          (rst),
      .cs           (cs),
      .spi_rx_valid (spi_rx_valid),
      .spi_rx_data  (spi_rx_data),
      .spi_tx_valid (spi_tx_valid),
      .spi_tx_data  (spi_tx_data),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_we       (reg_we),
      .reg_re       (reg_re),
      .reg_rdata    (reg_rdata),
      .intr         (intr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Register bank seen by the DUT and the bench's own view of what it should hold.
   logic [7:0] bank    [128];
   logic [7:0] mdl_mem [128];
   bit         m_pend = 1'b0;
   bit         m_ovr  = 1'b0;

   always @(posedge clk) begin
      if (reg_re) reg_rdata <= bank[reg_addr];
      if (reg_we) bank[reg_addr] <= reg_wdata;
   end

   logic [7:0]  tx_obs[$];
   logic [14:0] wr_obs[$];
   int          re_cnt   = 0;
   int          both_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (spi_tx_valid) tx_obs.push_back(spi_tx_data);
         if (reg_we) wr_obs.push_back({reg_addr, reg_wdata});
         if (reg_re) re_cnt++;
         if (reg_we && reg_re) both_cnt++;
      end
   end

   logic [7:0] fixed_q[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] w);
      spi_rx_valid = 1'b1;
      spi_rx_data  = w;
      tick(1);
      spi_rx_valid = 1'b0;
   endtask

   task automatic compare(input logic [7:0] exp_tx[$], input logic [14:0] exp_wr[$]);
      check_eq("tx_count", tx_obs.size(), exp_tx.size());
      foreach (exp_tx[i])
         check_eq($sformatf("tx_word%0d", i), (i < tx_obs.size()) ? tx_obs[i] : 8'hxx, exp_tx[i]);
      check_eq("wr_count", wr_obs.size(), exp_wr.size());
      foreach (exp_wr[i])
         check_eq($sformatf("wr%0d", i), (i < wr_obs.size()) ? wr_obs[i] : 15'hxxxx, exp_wr[i]);
   endtask

   task automatic run_frame(input logic [7:0] cmd, input int ndata);
      logic [7:0]  exp_tx[$];
      logic [14:0] exp_wr[$];
      logic [6:0]  a;
      logic [7:0]  w;
      tx_obs.delete();
      wr_obs.delete();
      exp_tx.push_back({4'hA, 2'b00, m_ovr, m_pend});
      a  = cmd[6:0];
      cs = 1'b0;
      tick(5);
      send(cmd);
      tick(10);
      if (!cmd[7]) begin
         m_pend = 1'b0;
         m_ovr  = 1'b0;
         check_eq("intr_clr_on_read", intr, 1'b0);
         exp_tx.push_back(mdl_mem[a]);
         a++;
      end
      for (int i = 0; i < ndata; i++) begin
         w = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
         send(w);
         tick(10);
         if (cmd[7]) begin
            exp_wr.push_back({a, w});
            mdl_mem[a] = w;
         end else begin
            exp_tx.push_back(mdl_mem[a]);
         end
         a++;
      end
      if (cmd[7] && ndata > 0) m_pend = 1'b1;
      cs = 1'b1;
      tick(6);
      compare(exp_tx, exp_wr);
      check_eq("intr", intr, m_pend);
   endtask

   // cs rises so the edge lands while the first fetch is in flight.
   task automatic abort_frame(input logic [6:0] addr);
      logic [7:0] s;
      tx_obs.delete();
      s      = {4'hA, 2'b00, m_ovr, m_pend};
      cs     = 1'b0;
      tick(5);
      re_cnt = 0;
      cs     = 1'b1;
      tick(1);
      send({1'b0, addr});
      tick(10);
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      check_eq("abort_tx_count", tx_obs.size(), 1);
      check_eq("abort_status", (tx_obs.size() > 0) ? tx_obs[0] : 8'hxx, s);
      check_eq("abort_re_count", re_cnt, 1);
      check_eq("abort_intr", intr, m_pend);
      tick(4);
   endtask

   // A second word arrives while the first fetch is still in progress.
   task automatic overrun_frame(input logic [6:0] addr);
      logic [7:0]  exp_tx[$];
      logic [14:0] exp_wr[$];
      tx_obs.delete();
      wr_obs.delete();
      exp_tx.push_back({4'hA, 2'b00, m_ovr, m_pend});
      cs = 1'b0;
      tick(5);
      spi_rx_valid = 1'b1;
      spi_rx_data  = {1'b0, addr};
      tick(1);
      spi_rx_data  = 8'h5A;
      tick(1);
      spi_rx_valid = 1'b0;
      tick(10);
      cs = 1'b1;
      tick(6);
      m_pend = 1'b0;
      m_ovr  = 1'b1;
      exp_tx.push_back(mdl_mem[addr]);
      compare(exp_tx, exp_wr);
   endtask

   task automatic reset_mid_write();
      wr_obs.delete();
      cs = 1'b0;
      tick(5);
      send(8'hB0);
      tick(4);
      spi_rx_valid = 1'b1;
      spi_rx_data  = 8'h77;
      tick(1);
      spi_rx_valid = 1'b0;
      check_eq("we_before_rst", reg_we, 1'b1);
      rst = 1'b0;
      #1;
      check_eq("outs_in_rst",
               {spi_tx_valid, spi_tx_data, reg_addr, reg_wdata, reg_we, reg_re, intr}, '0);
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      tick(2);
      cs = 1'b1;
      tick(3);
      rst = 1'b1;
      tick(10);
      check_eq("no_we_after_rst", wr_obs.size(), 0);
      check_eq("intr_after_rst", intr, 1'b0);
   endtask

   initial begin
      logic [7:0] c;
      for (int i = 0; i < 128; i++) begin
         bank[i]    = 8'($urandom);
         mdl_mem[i] = bank[i];
      end
      rst          = 1'b0;
      cs           = 1'b1;
      spi_rx_valid = 1'b0;
      spi_rx_data  = 8'h00;
      tick(3);
      check_eq("rst_tx_valid", spi_tx_valid, 1'b0);
      check_eq("rst_tx_data", spi_tx_data, 8'h00);
      check_eq("rst_reg_addr", reg_addr, 7'h00);
      check_eq("rst_strobes", {reg_we, reg_re}, 2'b00);
      check_eq("rst_intr", intr, 1'b0);
      rst = 1'b1;
      tick(3);

      fixed_q = '{8'h11, 8'h22};
      run_frame(8'h85, 2);
      check_eq("wr_frame_intr", intr, 1'b1);

      run_frame(8'h05, 2);
      check_eq("rd_status_a1", (tx_obs.size() > 0) ? tx_obs[0] : 8'hxx, 8'hA1);

      run_frame(8'hFF, 2);
      abort_frame(7'h10);
      run_frame(8'h10, 1);
      overrun_frame(7'h20);
      run_frame(8'h21, 1);
      check_eq("ovr_status_a2", (tx_obs.size() > 0) ? tx_obs[0] : 8'hxx, 8'hA2);

      run_frame(8'h40, 0);
      run_frame(8'hC0, 0);

      for (int f = 0; f < 20; f++) begin
         c[7]   = 1'($urandom_range(0, 1));
         c[6:0] = ($urandom_range(0, 3) == 0) ? 7'(7'h7D + $urandom_range(0, 2)) : 7'($urandom);
         run_frame(c, $urandom_range(0, 4));
      end

      reset_mid_write();
      run_frame(8'h83, 2);
      run_frame(8'h03, 2);

      check_eq("we_re_exclusive", both_cnt, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
